// File: rtl/ram16k_arbiter.sv
// rtl/ram16k_arbiter.sv - RAM16K owner: post-reset clear sweep, then two-port single-access arbitration
// Build macro RAM16K_ARB_RR_EN: round-robin on contention (default build: port A fixed priority)
module ram16k_arbiter #(
    parameter bit          CLEAR_ON_RESET = 1'b1,
    parameter int          CLEAR_DEPTH    = 16384,
    parameter logic [15:0] CLEAR_VALUE    = 16'h0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        a_req,
    input  logic        a_we,
    input  logic [13:0] a_addr,
    input  logic [15:0] a_wdata,
    output logic        a_gnt,
    output logic        a_rvalid,
    output logic [15:0] a_rdata,
    input  logic        b_req,
    input  logic        b_we,
    input  logic [13:0] b_addr,
    input  logic [15:0] b_wdata,
    output logic        b_gnt,
    output logic        b_rvalid,
    output logic [15:0] b_rdata,
    output logic        init_done,
    output logic        ram_load,
    output logic [13:0] ram_addr,
    output logic [15:0] ram_in,
    input  logic [15:0] ram_out
);
    typedef enum logic {ST_CLEAR, ST_RUN} state_t;

    localparam logic [13:0] CLR_LAST = 14'(CLEAR_DEPTH - 1);

    state_t      state_q, state_d;
    logic [13:0] clr_cnt_q, clr_cnt_d;
    logic        last_gnt_b_q, last_gnt_b_d;
    logic        a_rvalid_q, a_rvalid_d;
    logic        b_rvalid_q, b_rvalid_d;
    logic        init_done_q, init_done_d;
    logic [13:0] addr_hold_q, addr_hold_d;
    logic [15:0] din_hold_q, din_hold_d;
    logic        running;
    logic        a_wins;

    // Arbitration: A wins whenever B is idle; on contention the build decides.
    always_comb begin
        running = (state_q == ST_RUN) && !reset;
`ifdef RAM16K_ARB_RR_EN
        a_wins  = last_gnt_b_q;
`else
        a_wins  = 1'b1;
`endif
        a_gnt   = running && a_req && (!b_req || a_wins);
        b_gnt   = running && b_req && !a_gnt;
    end

    // RAM side: sweep owns the RAM during CLEAR; idle cycles hold addr/data stable.
    always_comb begin
        ram_load = 1'b0;
        ram_addr = addr_hold_q;
        ram_in   = din_hold_q;
        if (!reset) begin
            if (state_q == ST_CLEAR) begin
                ram_load = 1'b1;
                ram_addr = clr_cnt_q;
                ram_in   = CLEAR_VALUE;
            end else if (a_gnt) begin
                ram_load = a_we;
                ram_addr = a_addr;
                ram_in   = a_wdata;
            end else if (b_gnt) begin
                ram_load = b_we;
                ram_addr = b_addr;
                ram_in   = b_wdata;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        clr_cnt_d    = clr_cnt_q;
        last_gnt_b_d = last_gnt_b_q;
        addr_hold_d  = ram_addr;
        din_hold_d   = ram_in;
        if (state_q == ST_CLEAR) begin
            clr_cnt_d = clr_cnt_q + 14'd1;
            if (clr_cnt_q == CLR_LAST) begin
                state_d = ST_RUN;
            end
        end
        if (a_gnt) begin
            last_gnt_b_d = 1'b0;
        end else if (b_gnt) begin
            last_gnt_b_d = 1'b1;
        end
        init_done_d = (state_d == ST_RUN);
        a_rvalid_d  = a_gnt && !a_we;
        b_rvalid_d  = b_gnt && !b_we;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;
            clr_cnt_q    <= 14'd0;
            last_gnt_b_q <= 1'b1;
            a_rvalid_q   <= 1'b0;
            b_rvalid_q   <= 1'b0;
            init_done_q  <= !CLEAR_ON_RESET;
            addr_hold_q  <= 14'd0;
            din_hold_q   <= 16'd0;
        end else begin
            state_q      <= state_d;
            clr_cnt_q    <= clr_cnt_d;
            last_gnt_b_q <= last_gnt_b_d;
            a_rvalid_q   <= a_rvalid_d;
            b_rvalid_q   <= b_rvalid_d;
            init_done_q  <= init_done_d;
            addr_hold_q  <= addr_hold_d;
            din_hold_q   <= din_hold_d;
        end
    end

    // A reset arriving while a read is in flight kills its response pulse.
    always_comb begin
        init_done = init_done_q && !reset;
        a_rvalid  = a_rvalid_q && !reset;
        b_rvalid  = b_rvalid_q && !reset;
        a_rdata   = a_rvalid ? ram_out : 16'h0000;
        b_rdata   = b_rvalid ? ram_out : 16'h0000;
    end
endmodule

// File: tb/tb_ram16k_arbiter.sv
// tb/tb_ram16k_arbiter.sv - scoreboard bench for ram16k_arbiter with behavioural memory/arbitration model
module tb_ram16k_arbiter;
    localparam int          DEPTH = 8;
    localparam logic [15:0] CVAL  = 16'h0000;
`ifdef RAM16K_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic        a_req = 0, a_we = 0, b_req = 0, b_we = 0;
    logic [13:0] a_addr = 0, b_addr = 0;
    logic [15:0] a_wdata = 0, b_wdata = 0;
    logic        a_gnt, a_rvalid, b_gnt, b_rvalid, init_done, ram_load;
    logic [15:0] a_rdata, b_rdata, ram_in, ram_out;
    logic [13:0] ram_addr;

    logic        a1_req = 0;
    logic        a1_gnt, a1_rvalid, b1_gnt, b1_rvalid, init_done1, ram_load1;
    logic [15:0] a1_rdata, b1_rdata, ram_in1;
    logic [13:0] ram_addr1;

    ram16k_arbiter #(.CLEAR_ON_RESET(1'b1), .CLEAR_DEPTH(DEPTH), .CLEAR_VALUE(CVAL)) dut (
        .clk(clk), .reset(reset),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
        .init_done(init_done), .ram_load(ram_load), .ram_addr(ram_addr),
        .ram_in(ram_in), .ram_out(ram_out)
    );

    ram16k_arbiter #(.CLEAR_ON_RESET(1'b0), .CLEAR_DEPTH(DEPTH), .CLEAR_VALUE(CVAL)) u_noclr (
        .clk(clk), .reset(reset),
        .a_req(a1_req), .a_we(1'b0), .a_addr(14'd0), .a_wdata(16'd0),
        .a_gnt(a1_gnt), .a_rvalid(a1_rvalid), .a_rdata(a1_rdata),
        .b_req(1'b0), .b_we(1'b0), .b_addr(14'd0), .b_wdata(16'd0),
        .b_gnt(b1_gnt), .b_rvalid(b1_rvalid), .b_rdata(b1_rdata),
        .init_done(init_done1), .ram_load(ram_load1), .ram_addr(ram_addr1),
        .ram_in(ram_in1), .ram_out(16'h0000)
    );

    // RAM16K stand-in: registered read, write on the same edge.
    logic [15:0] ram_mem [0:16383];
    initial for (int i = 0; i < 16384; i++) ram_mem[i] = 16'hDEAD;
    always @(posedge clk) begin
        ram_out <= ram_mem[ram_addr];
        if (ram_load) ram_mem[ram_addr] <= ram_in;
    end

    int vectors = 0, fails = 0, cyc = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    typedef struct {
        int          due;
        logic [15:0] data;
    } rd_t;
    rd_t qa[$], qb[$];

    logic [15:0] ref_mem [0:16383];
    initial for (int i = 0; i < 16384; i++) ref_mem[i] = 16'hDEAD;
    bit          m_run = 0, m_last_b = 1;
    int          swp = 0;
    logic        ea, eb, m_we;
    logic [13:0] m_ad;
    logic [15:0] m_wd;

    always @(negedge clk) begin
        cyc++;
        if (reset) begin
            chk("rst_init_done", init_done, 0);
            chk("rst_a_gnt", a_gnt, 0);
            chk("rst_b_gnt", b_gnt, 0);
            chk("rst_ram_load", ram_load, 0);
            chk("rst_a_rvalid", a_rvalid, 0);
            chk("rst_b_rvalid", b_rvalid, 0);
            m_run = 0; m_last_b = 1; swp = 0;
            qa.delete(); qb.delete();
        end else begin
            if (qa.size() > 0 && qa[0].due == cyc) begin
                chk("a_rvalid", a_rvalid, 1);
                chk("a_rdata", a_rdata, qa[0].data);
                void'(qa.pop_front());
            end else begin
                chk("a_rvalid_idle", a_rvalid, 0);
                chk("a_rdata_idle", a_rdata, 0);
            end
            if (qb.size() > 0 && qb[0].due == cyc) begin
                chk("b_rvalid", b_rvalid, 1);
                chk("b_rdata", b_rdata, qb[0].data);
                void'(qb.pop_front());
            end else begin
                chk("b_rvalid_idle", b_rvalid, 0);
                chk("b_rdata_idle", b_rdata, 0);
            end
            if (!m_run) begin
                chk("swp_load", ram_load, 1);
                chk("swp_addr", ram_addr, swp);
                chk("swp_data", ram_in, CVAL);
                chk("swp_a_gnt", a_gnt, 0);
                chk("swp_b_gnt", b_gnt, 0);
                chk("swp_init_done", init_done, 0);
                ref_mem[swp] = CVAL;
                swp++;
                if (swp == DEPTH) m_run = 1;
            end else begin
                chk("run_init_done", init_done, 1);
                ea = a_req && (!b_req || !RR || m_last_b);
                eb = b_req && !ea;
                chk("a_gnt", a_gnt, ea);
                chk("b_gnt", b_gnt, eb);
                if (ea || eb) begin
                    m_we = ea ? a_we : b_we;
                    m_ad = ea ? a_addr : b_addr;
                    m_wd = ea ? a_wdata : b_wdata;
                    chk("ram_load", ram_load, m_we);
                    chk("ram_addr", ram_addr, m_ad);
                    if (m_we) begin
                        chk("ram_in", ram_in, m_wd);
                        ref_mem[m_ad] = m_wd;
                    end else if (ea) begin
                        qa.push_back('{cyc + 1, ref_mem[m_ad]});
                    end else begin
                        qb.push_back('{cyc + 1, ref_mem[m_ad]});
                    end
                    m_last_b = eb;
                end else begin
                    chk("idle_ram_load", ram_load, 0);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic wait_gnt_a(input string nm);
        bit got = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (a_gnt) begin
                got = 1;
                break;
            end
        end
        chk(nm, got, 1);
        @(posedge clk); #1;
    endtask

    task automatic new_a();
        a_req = ($urandom % 4) != 0; a_we = $urandom % 2;
        a_addr = 14'($urandom % 16); a_wdata = 16'($urandom);
    endtask

    task automatic new_b();
        b_req = ($urandom % 4) != 0; b_we = $urandom % 2;
        b_addr = 14'($urandom % 16); b_wdata = 16'($urandom);
    endtask

    int  na;
    bit  ga, gb;

    initial begin
        a_req = 1; a_we = 0; a_addr = 14'd3; a1_req = 1;
        @(negedge clk);
        chk("noclr_rst_init_done", init_done1, 0);
        chk("noclr_rst_gnt", a1_gnt, 0);
        @(posedge clk); #1 reset = 0;
        @(negedge clk);
        chk("noclr_init_done", init_done1, 1);
        chk("noclr_a_gnt", a1_gnt, 1);
        a1_req = 0;
        wait_gnt_a("sweep_then_gnt");

        a_req = 1; a_we = 1; a_addr = 14'h0005; a_wdata = 16'h1234;
        wait_gnt_a("wr_gnt");
        a_we = 0;
        wait_gnt_a("rd_gnt");
        a_req = 0;
        @(negedge clk);
        chk("rd_1234_valid", a_rvalid, 1);
        chk("rd_1234_data", a_rdata, 16'h1234);
        @(posedge clk); #1;

        a_req = 1; a_we = 0; a_addr = 14'd1;
        b_req = 1; b_we = 0; b_addr = 14'd2;
        na = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (a_gnt) na++;
            @(posedge clk); #1;
        end
        a_req = 0; b_req = 0;
        chk("contend_a_count", na, RR ? 2 : 4);
        repeat (2) @(posedge clk); #1;

        a_req = 1; a_we = 0; a_addr = 14'd4;
        wait_gnt_a("pre_reset_rd_gnt");
        reset = 1; a_req = 0;
        @(negedge clk);
        chk("reset_kills_rvalid", a_rvalid, 0);
        @(posedge clk); #1 reset = 0;

        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            ga = a_gnt; gb = b_gnt;
            @(posedge clk); #1;
            reset = (n == 200);
            if (ga || !a_req) new_a();
            if (gb || !b_req) new_b();
        end
        reset = 0; a_req = 0; b_req = 0;
        repeat (12) @(posedge clk);
        #1;
        chk("drain_a", qa.size(), 0);
        chk("drain_b", qb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end
endmodule
